seq_acceptor: RTL
=================

// Module: seq_acceptor
// PURPOSE
//  Parametrised d-pad sequence acceptor. Compares released buttons against a runtime-programmable
//  sequence (Konami code at reset). Enforces an inter-press timeout and reports accept/reject.
//  Sits between per-button debouncers and the display coder/driver; state_code feeds the coder.
// PARAMETERS
//  NUM_BTN        4        number of button inputs (>=2); BTN_W = $clog2(NUM_BTN)
//  SEQ_LEN        8        sequence storage depth = max sequence length (>=1); PROG_W = $clog2(SEQ_LEN+1)
//  DEFAULT_SEQ    16'hEE50 reset sequence, SEQ_LEN*BTN_W bits, entry i at [i*BTN_W +: BTN_W]
//                          (0=up,1=down,2=left,3=right -> U,U,D,D,L,R,L,R)
//  TIMEOUT_CYCLES 2**25    max cycles between releases while matching
//  MAX_FAILS      3        consecutive rejects before lockout (LOCKOUT only)
//  LOCK_CYCLES    2**26    lockout duration in cycles (LOCKOUT only)
// PORTS
//  clk          in   1                 clock
//  reset        in   1                 synchronous, active-high reset
//  btn          in   NUM_BTN           debounced button levels, 1 = pressed
//  prog_we      in   1                 write prog_btn into seq entry prog_addr
//  prog_addr    in   $clog2(SEQ_LEN)   entry index
//  prog_btn     in   BTN_W             button code for entry
//  prog_len_we  in   1                 write prog_len into length register
//  prog_len     in   PROG_W            new length, legal 1..SEQ_LEN
//  state_code   out  3                 0 IDLE, 1 MATCH, 2 ACCEPT, 3 REJECT, 4 LOCKED
//  progress     out  PROG_W            entries matched so far
//  accept_pulse out  1                 1-cycle pulse on entry to ACCEPT
//  reject_pulse out  1                 1-cycle pulse on every reject, including one that enters LOCKED
//  locked       out  1                 high while in LOCKED
// BEHAVIOUR
//  Reset: state IDLE, progress 0, pulses 0, locked 0, btn_q 0, seq = DEFAULT_SEQ, len = SEQ_LEN, counters 0.
//  Release: rel[i] = btn_q[i] & ~btn[i]; btn_q <= btn every cycle. A single release has exactly one rel bit set.
//   Multi-release: more than one rel bit set in the same cycle.
//  All transitions occur at the edge ending the cycle in which rel is seen.
//  IDLE: single release == seq[0] -> MATCH, progress = 1; if len == 1 -> ACCEPT directly.
//   Any other release is ignored.
//  MATCH:
//   - Single release == seq[progress]: progress++. If the new progress == len -> ACCEPT.
//   - Wrong single release or multi-release -> REJECT.
//   - Timeout: tmo_cnt == TIMEOUT_CYCLES-1 with no release in that cycle -> REJECT.
//   - tmo_cnt clears on any release and whenever state != MATCH. A release in the timeout cycle wins.
//  ACCEPT / REJECT: hold until any release (single or multi), then -> IDLE, progress 0.
//   That release does not begin a new sequence.
//  Programming:
//   - prog_we writes an entry. prog_len_we with prog_len 0 or > SEQ_LEN is ignored.
//   - Any programming write while in MATCH aborts to IDLE, progress 0, no pulse. This overrides a
//     simultaneous release or timeout.
//   - The write takes effect for the comparison in the next cycle.
//  progress is cleared on entering IDLE or REJECT and holds len in ACCEPT.
// CONFIGURATION
//  SEQ_ACCEPTOR_LOCKOUT_EN defined:
//   - fail_cnt counts consecutive rejects; ACCEPT clears it.
//   - The reject that makes fail_cnt == MAX_FAILS goes to LOCKED instead of REJECT.
//   - LOCKED: all releases and programming writes are ignored (writes dropped).
//   - After LOCK_CYCLES cycles -> IDLE, fail_cnt = 0.
//  Macro undefined: fail_cnt and lock_cnt are absent, LOCKED is unreachable, locked is tied 0.
// STRUCTURE
//  seq_acceptor_pkg: state enum/codes, button code constants (BTN_UP..BTN_RIGHT), KONAMI_SEQ constant.
//  Sub-module seq_release_detect: holds btn_q, outputs rel vector, single flag, encoded index (BTN_W).
//  Top level holds the sequence regfile, length register, FSM, timeout/lock counters.
// TESTING
//  1 Defaults, release U,U,D,D,L,R,L,R 10 cycles apart -> progress 1..8, state_code 2, accept_pulse exactly once.
//  2 U,U,L -> reject_pulse on the L cycle, state_code 3; then release D -> state_code 0, progress 0.
//  3 TIMEOUT_CYCLES=16: release U, then idle -> REJECT exactly 16 cycles after the release.
//   Releasing U on cycle 16 -> progress 2 instead.
//  4 U and D released in the same cycle during MATCH -> REJECT. In IDLE: stays IDLE.
//  5 Program len=3, seq=R,L,R; release R,L,R -> ACCEPT.
//   prog_we mid-match -> IDLE, no pulse. prog_len=0 -> len unchanged.
//  6 LOCKOUT_EN, MAX_FAILS=3, LOCK_CYCLES=32: third consecutive wrong sequence -> reject_pulse, locked=1,
//   inputs ignored for 32 cycles, then IDLE. Mid-run reset -> all reset values next cycle.

Source files
------------

// File: rtl/seq_acceptor_pkg.sv
// Shared types and constants for the d-pad sequence acceptor.
// Lockout support in seq_acceptor is enabled by defining SEQ_ACCEPTOR_LOCKOUT_EN.
package seq_acceptor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MATCH  = 3'd1,
        ST_ACCEPT = 3'd2,
        ST_REJECT = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    localparam logic [1:0] BTN_UP    = 2'd0;
    localparam logic [1:0] BTN_DOWN  = 2'd1;
    localparam logic [1:0] BTN_LEFT  = 2'd2;
    localparam logic [1:0] BTN_RIGHT = 2'd3;

    // Entry 0 sits in the least significant bits: U,U,D,D,L,R,L,R.
    localparam logic [15:0] KONAMI_SEQ = {BTN_RIGHT, BTN_LEFT, BTN_RIGHT, BTN_LEFT,
                                          BTN_DOWN, BTN_DOWN, BTN_UP, BTN_UP};

    // Width helper that never returns zero, so degenerate parameters still give legal vectors.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/seq_release_detect.sv
// Turns debounced button levels into release events: a release vector, a
// "exactly one released" flag and the index of the (lowest) released button.
module seq_release_detect
    import seq_acceptor_pkg::*;
#(
    parameter int NUM_BTN = 4,
    parameter int BTN_W   = clog2_min1(NUM_BTN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] rel,
    output logic               single,
    output logic [BTN_W-1:0]   idx
);

    logic [NUM_BTN-1:0] btn_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn;
        end
    end

    assign rel    = btn_q & ~btn;
    assign single = (rel != '0) && ((rel & (rel - NUM_BTN'(1))) == '0);

    always_comb begin
        idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (rel[i]) begin
                idx = BTN_W'(i);
            end
        end
    end

endmodule

// File: rtl/seq_acceptor.sv
// Runtime-programmable d-pad sequence acceptor with inter-release timeout.
// Define SEQ_ACCEPTOR_LOCKOUT_EN to add the consecutive-reject lockout state.
module seq_acceptor
    import seq_acceptor_pkg::*;
#(
    parameter int NUM_BTN = 4,
    parameter int SEQ_LEN = 8,
    parameter logic [SEQ_LEN*clog2_min1(NUM_BTN)-1:0] DEFAULT_SEQ = KONAMI_SEQ,
    parameter int TIMEOUT_CYCLES = 2**25,
    parameter int MAX_FAILS = 3,
    parameter int LOCK_CYCLES = 2**26
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_BTN-1:0]                  btn,
    input  logic                                prog_we,
    input  logic [clog2_min1(SEQ_LEN)-1:0]      prog_addr,
    input  logic [clog2_min1(NUM_BTN)-1:0]      prog_btn,
    input  logic                                prog_len_we,
    input  logic [$clog2(SEQ_LEN+1)-1:0]        prog_len,
    output logic [2:0]                          state_code,
    output logic [$clog2(SEQ_LEN+1)-1:0]        progress,
    output logic                                accept_pulse,
    output logic                                reject_pulse,
    output logic                                locked
);

    localparam int BTN_W  = clog2_min1(NUM_BTN);
    localparam int PROG_W = $clog2(SEQ_LEN + 1);
    localparam int ADDR_W = clog2_min1(SEQ_LEN);
    localparam int TMO_W  = clog2_min1(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [NUM_BTN-1:0] rel;
    logic               single;
    logic [BTN_W-1:0]   idx;
    logic               any_rel;

    logic [BTN_W-1:0]   seq_mem [SEQ_LEN];
    logic [PROG_W-1:0]  seq_len;
    state_t             state;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [PROG_W-1:0]  nxt_prog;

    logic len_ok, prog_hit, wr_allow, cur_match;
    logic accept_ev, reject_ev, advance_ev, clear_ev;

    seq_release_detect #(
        .NUM_BTN (NUM_BTN),
        .BTN_W   (BTN_W)
    ) u_rel (
        .clk    (clk),
        .reset  (reset),
        .btn    (btn),
        .rel    (rel),
        .single (single),
        .idx    (idx)
    );

    assign any_rel    = |rel;
    assign state_code = state;
    assign nxt_prog   = progress + PROG_W'(1);
    assign len_ok     = prog_len_we && (prog_len != '0) && (prog_len <= PROG_W'(SEQ_LEN));
    assign prog_hit   = prog_we || len_ok;
    assign wr_allow   = (state != ST_LOCKED);
    // progress is 0 in IDLE, so the same lookup serves the first entry too.
    assign cur_match  = single && (idx == seq_mem[progress[ADDR_W-1:0]]);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                seq_mem[i] <= DEFAULT_SEQ[i*BTN_W +: BTN_W];
            end
            seq_len <= PROG_W'(SEQ_LEN);
        end else if (wr_allow) begin
            if (prog_we) begin
                seq_mem[prog_addr] <= prog_btn;
            end
            if (len_ok) begin
                seq_len <= prog_len;
            end
        end
    end

    always_comb begin
        accept_ev  = 1'b0;
        reject_ev  = 1'b0;
        advance_ev = 1'b0;
        clear_ev   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cur_match) begin
                    if (nxt_prog == seq_len) accept_ev = 1'b1;
                    else                     advance_ev = 1'b1;
                end
            end
            ST_MATCH: begin
                // A programming write wins over both a release and a timeout.
                if (prog_hit) begin
                    clear_ev = 1'b1;
                end else if (any_rel) begin
                    if (cur_match) begin
                        if (nxt_prog == seq_len) accept_ev = 1'b1;
                        else                     advance_ev = 1'b1;
                    end else begin
                        reject_ev = 1'b1;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    reject_ev = 1'b1;
                end
            end
            ST_ACCEPT, ST_REJECT: begin
                if (any_rel) clear_ev = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef SEQ_ACCEPTOR_LOCKOUT_EN
    localparam int FAIL_W = clog2_min1(MAX_FAILS + 1);
    localparam int LOCK_W = clog2_min1(LOCK_CYCLES);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    logic [FAIL_W-1:0] fail_cnt;
    logic [LOCK_W-1:0] lock_cnt;
`else
    logic unused_lock_cfg;
    assign unused_lock_cfg = ^{MAX_FAILS, LOCK_CYCLES};
    assign locked = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            progress     <= '0;
            accept_pulse <= 1'b0;
            reject_pulse <= 1'b0;
            tmo_cnt      <= '0;
`ifdef SEQ_ACCEPTOR_LOCKOUT_EN
            locked       <= 1'b0;
            fail_cnt     <= '0;
            lock_cnt     <= '0;
`endif
        end else begin
            accept_pulse <= accept_ev;
            reject_pulse <= reject_ev;
            if (state == ST_MATCH && !any_rel && !reject_ev && !clear_ev) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end

            if (accept_ev) begin
                state    <= ST_ACCEPT;
                progress <= nxt_prog;
`ifdef SEQ_ACCEPTOR_LOCKOUT_EN
                fail_cnt <= '0;
`endif
            end else if (advance_ev) begin
                state    <= ST_MATCH;
                progress <= nxt_prog;
            end else if (reject_ev) begin
                progress <= '0;
`ifdef SEQ_ACCEPTOR_LOCKOUT_EN
                fail_cnt <= fail_cnt + FAIL_W'(1);
                if (fail_cnt == FAIL_LAST) begin
                    state    <= ST_LOCKED;
                    locked   <= 1'b1;
                    lock_cnt <= '0;
                end else begin
                    state <= ST_REJECT;
                end
`else
                state <= ST_REJECT;
`endif
            end else if (clear_ev) begin
                state    <= ST_IDLE;
                progress <= '0;
            end
`ifdef SEQ_ACCEPTOR_LOCKOUT_EN
            else if (state == ST_LOCKED) begin
                if (lock_cnt == LOCK_LAST) begin
                    state    <= ST_IDLE;
                    locked   <= 1'b0;
                    fail_cnt <= '0;
                    lock_cnt <= '0;
                end else begin
                    lock_cnt <= lock_cnt + LOCK_W'(1);
                end
            end
`endif
        end
    end

endmodule
